tmds_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 13 +
 rtl/tmds_word_decode.sv | 34 +++
 rtl/tmds_decoder.sv | 162 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS word width, control-token constants and aligner state type.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [TMDS_WORD_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic {SEARCH, LOCKED} tmds_align_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational decode of one aligned TMDS word into
// control-token flag/bits or the recovered 8-bit video byte.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_WORD_W-1:0] i_word,
  output logic                   o_is_ctrl,
  output logic [1:0]             o_control,
  output logic [7:0]             o_data
);

  logic [7:0] w_q;

  assign w_q = i_word[9] ? ~i_word[7:0] : i_word[7:0];

  always_comb begin
    o_is_ctrl = 1'b1;
    o_control = 2'b00;
    o_data    = 8'h00;
    // Undo the transition-minimising XOR/XNOR chain.
    o_data[0] = w_q[0];
    for (int k = 1; k < 8; k++) begin
      o_data[k] = i_word[8] ? (w_q[k] ^ w_q[k-1]) : ~(w_q[k] ^ w_q[k-1]);
    end
    case (i_word)
      CTRL_TOKEN_00: o_control = 2'b00;
      CTRL_TOKEN_01: o_control = 2'b01;
      CTRL_TOKEN_10: o_control = 2'b10;
      CTRL_TOKEN_11: o_control = 2'b11;
      default:       o_is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel word aligner and decoder; defining
// TMDS_DEC_STATS_EN adds saturating offset-slip and lock-loss counters.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [TMDS_WORD_W-1:0] raw_in,
  output logic [7:0]             data_out,
  output logic [1:0]             control_out,
  output logic                   ve_out,
  output logic                   locked_out,
  output logic [3:0]             offset_out
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0]            slip_count_out,
  output logic [15:0]            loss_count_out
`endif
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT);

  logic [TMDS_WORD_W-1:0]   r_word_q, r_word_qq;
  logic [2*TMDS_WORD_W-1:0] w_window;
  logic [TMDS_WORD_W-1:0]   w_aligned;
  logic                     w_is_ctrl;
  logic [1:0]               w_ctrl;
  logic [7:0]               w_data;

  tmds_align_state_t r_state, w_state_n;
  logic [3:0]        r_offset, w_offset_n;
  logic [RUN_W-1:0]  r_run, w_run_n;
  logic [TMO_W-1:0]  r_tmo, w_tmo_n;
  logic [LOSS_W-1:0] r_loss, w_loss_n;

  logic [7:0] r_data;
  logic [1:0] r_ctrl;
  logic       r_ve, r_locked;

  // Older word sits in the low half so the window reads in arrival order.
  assign w_window  = {r_word_q, r_word_qq};
  assign w_aligned = w_window[{1'b0, r_offset} +: TMDS_WORD_W];

  tmds_word_decode u_word_decode (
    .i_word    (w_aligned),
    .o_is_ctrl (w_is_ctrl),
    .o_control (w_ctrl),
    .o_data    (w_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_word_q  <= '0;
      r_word_qq <= '0;
      r_state   <= SEARCH;
      r_offset  <= 4'd0;
      r_run     <= '0;
      r_tmo     <= '0;
      r_loss    <= '0;
    end else begin
      r_word_q  <= raw_in;
      r_word_qq <= r_word_q;
      r_state   <= w_state_n;
      r_offset  <= w_offset_n;
      r_run     <= w_run_n;
      r_tmo     <= w_tmo_n;
      r_loss    <= w_loss_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_offset_n = r_offset;
    w_run_n    = r_run;
    w_tmo_n    = r_tmo;
    w_loss_n   = r_loss;
    case (r_state)
      SEARCH: begin
        if (!w_is_ctrl)                       w_run_n = '0;
        else if (r_run < RUN_W'(LOCK_COUNT))  w_run_n = r_run + RUN_W'(1);
        if (r_tmo != TMO_W'(SEARCH_TIMEOUT - 1)) w_tmo_n = r_tmo + TMO_W'(1);
        // Lock takes priority over a coincident timeout.
        if (w_is_ctrl && r_run == RUN_W'(LOCK_COUNT - 1)) begin
          w_state_n = LOCKED;
          w_run_n   = '0;
          w_tmo_n   = '0;
        end else if (r_tmo == TMO_W'(SEARCH_TIMEOUT - 1)) begin
          w_offset_n = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
          w_run_n    = '0;
          w_tmo_n    = '0;
        end
      end
      LOCKED: begin
        if (w_is_ctrl)                               w_loss_n = '0;
        else if (r_loss != LOSS_W'(LOSS_TIMEOUT - 1)) w_loss_n = r_loss + LOSS_W'(1);
        if (!w_is_ctrl && r_loss == LOSS_W'(LOSS_TIMEOUT - 1)) begin
          w_state_n = SEARCH;
          w_loss_n  = '0;
          w_run_n   = '0;
          w_tmo_n   = '0;
        end
      end
      default: w_state_n = SEARCH;
    endcase
  end

  // Output uses the pre-transition state, so the lock/loss trigger word keeps the old status.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_data   <= 8'h00;
      r_ctrl   <= 2'b00;
      r_ve     <= 1'b0;
      r_locked <= 1'b0;
    end else if (r_state == LOCKED) begin
      r_locked <= 1'b1;
      if (w_is_ctrl) begin
        r_ve   <= 1'b0;
        r_ctrl <= w_ctrl;
      end else begin
        r_ve   <= 1'b1;
        r_data <= w_data;
      end
    end else begin
      r_locked <= 1'b0;
      r_ve     <= 1'b0;
      r_data   <= 8'h00;
      r_ctrl   <= 2'b00;
    end
  end

  assign data_out    = r_data;
  assign control_out = r_ctrl;
  assign ve_out      = r_ve;
  assign locked_out  = r_locked;
  assign offset_out  = r_offset;

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] r_slip_cnt, r_loss_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_slip_cnt <= 16'h0000;
      r_loss_cnt <= 16'h0000;
    end else begin
      if (w_offset_n != r_offset && r_slip_cnt != 16'hFFFF)
        r_slip_cnt <= r_slip_cnt + 16'h0001;
      if (r_state == LOCKED && w_state_n == SEARCH && r_loss_cnt != 16'hFFFF)
        r_loss_cnt <= r_loss_cnt + 16'h0001;
    end
  end

  assign slip_count_out = r_slip_cnt;
  assign loss_count_out = r_loss_cnt;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder (lock, decode, slip, loss, wrap, reset).
module tb_tmds_decoder;
  import tmds_pkg::*;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [9:0] raw_in   = 10'h000;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out, locked_out;
  logic [3:0] offset_out;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_count_out, loss_count_out;
`endif

  always #5 clk_in = ~clk_in;

  tmds_decoder dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .raw_in      (raw_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .locked_out  (locked_out),
    .offset_out  (offset_out)
`ifdef TMDS_DEC_STATS_EN
    ,
    .slip_count_out (slip_count_out),
    .loss_count_out (loss_count_out)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ve;
    logic       locked;
  } exp_t;

  typedef struct {
    logic [9:0] raw;
    logic       tok;
    logic [7:0] val;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [7:0] m_data = 8'h00;
  logic [1:0] m_ctrl = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs are queued at drive time; each word appears three edges later.
  task automatic drive(input logic [9:0] w, input logic lk, input logic tok, input logic [7:0] val);
    exp_t e;
    if (!lk) begin
      m_data = 8'h00;
      m_ctrl = 2'b00;
      e.ve   = 1'b0;
    end else if (tok) begin
      m_ctrl = val[1:0];
      e.ve   = 1'b0;
    end else begin
      m_data = val;
      e.ve   = 1'b1;
    end
    e.data   = m_data;
    e.ctrl   = m_ctrl;
    e.locked = lk;
    sb.push_back(e);
    raw_in = w;
    @(posedge clk_in);
    #1;
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      chk("sb_locked", {31'd0, locked_out}, {31'd0, e.locked});
      chk("sb_ve", {31'd0, ve_out}, {31'd0, e.ve});
      chk("sb_data", {24'd0, data_out}, {24'd0, e.data});
      chk("sb_ctrl", {30'd0, control_out}, {30'd0, e.ctrl});
    end
  endtask

  task automatic tick(input logic [9:0] w);
    raw_in = w;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, locked_out}, 32'd0);
    chk({tag, "_ve"}, {31'd0, ve_out}, 32'd0);
    chk({tag, "_data"}, {24'd0, data_out}, 32'd0);
    chk({tag, "_ctrl"}, {30'd0, control_out}, 32'd0);
    chk({tag, "_offset"}, {28'd0, offset_out}, 32'd0);
`ifdef TMDS_DEC_STATS_EN
    chk({tag, "_slips"}, {16'd0, slip_count_out}, 32'd0);
    chk({tag, "_losses"}, {16'd0, loss_count_out}, 32'd0);
`endif
  endtask

  task automatic reset_dut();
    rst_n_in = 1'b0;
    raw_in   = 10'h000;
    sb.delete();
    m_data = 8'h00;
    m_ctrl = 2'b00;
    repeat (2) @(posedge clk_in);
    #1;
    check_zero("reset");
    rst_n_in = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[11];
    int   slip_e[$];
    int   slip_v[$];
    int   lock_e;
    int   any_lock;
    logic [3:0] last_off;

    vt[0]  = '{10'h100, 1'b0, 8'h00};
    vt[1]  = '{10'h200, 1'b0, 8'hFF};
    vt[2]  = '{10'h2AB, 1'b1, 8'h03};
    vt[3]  = '{10'h354, 1'b1, 8'h00};
    vt[4]  = '{10'h1FF, 1'b0, 8'h01};
    vt[5]  = '{10'h0AB, 1'b1, 8'h01};
    vt[6]  = '{10'h102, 1'b0, 8'h06};
    vt[7]  = '{10'h154, 1'b1, 8'h02};
    vt[8]  = '{10'h3C0, 1'b0, 8'h41};
    vt[9]  = '{10'h0F0, 1'b0, 8'hEE};
    vt[10] = '{10'h155, 1'b0, 8'hFF};

    // Lock at offset 0, then decode table while locked.
    reset_dut();
    for (int i = 0; i < 8; i++) drive(CTRL_TOKEN_00, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 11; i++) drive(vt[i].raw, 1'b1, vt[i].tok, vt[i].val);

    // Lock loss after 4096 tokenless words.
    drive(CTRL_TOKEN_00, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 4096; i++) drive(10'h100, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(10'h100, 1'b0, 1'b0, 8'h00);
    chk("loss_offset", {28'd0, offset_out}, 32'd0);
`ifdef TMDS_DEC_STATS_EN
    chk("loss_count", {16'd0, loss_count_out}, 32'd1);
`endif

    // Asynchronous reset while locked, then relock.
    reset_dut();
    for (int i = 0; i < 8; i++) drive(CTRL_TOKEN_00, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) drive(10'h200, 1'b1, 1'b0, 8'hFF);
    chk("pre_reset_locked", {31'd0, locked_out}, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_zero("async_reset");
    sb.delete();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 8; i++) drive(CTRL_TOKEN_00, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) drive(10'h102, 1'b1, 1'b0, 8'h06);

    // Token stream with boundaries at bit 3: three slips, then lock at offset 3.
    reset_dut();
    last_off = offset_out;
    lock_e = 0;
    for (int e = 1; e <= 6200; e++) begin
      tick(10'h2A6);
      if (offset_out != last_off) begin
        slip_e.push_back(e);
        slip_v.push_back(int'(offset_out));
        last_off = offset_out;
      end
      if (locked_out && lock_e == 0) lock_e = e;
    end
    chk("slip_num", slip_e.size(), 32'd3);
    for (int i = 0; i < slip_e.size() && i < 3; i++) begin
      chk("slip_edge", slip_e[i], 2048 * (i + 1));
      chk("slip_val", slip_v[i], i + 1);
    end
    chk("slip_lock_edge", lock_e, 32'd6153);
    chk("slip_offset", {28'd0, offset_out}, 32'd3);
    chk("slip_locked", {31'd0, locked_out}, 32'd1);
    chk("slip_ve", {31'd0, ve_out}, 32'd0);
    chk("slip_ctrl", {30'd0, control_out}, 32'd0);
`ifdef TMDS_DEC_STATS_EN
    chk("slip_count", {16'd0, slip_count_out}, 32'd3);
`endif

    // Tokenless stream: offset steps 1..9 then wraps to 0.
    reset_dut();
    slip_e.delete();
    slip_v.delete();
    last_off = offset_out;
    any_lock = 0;
    for (int e = 1; e <= 10 * 2048 + 5; e++) begin
      tick(10'h000);
      if (offset_out != last_off) begin
        slip_e.push_back(e);
        slip_v.push_back(int'(offset_out));
        last_off = offset_out;
      end
      if (locked_out) any_lock = 1;
    end
    chk("wrap_num", slip_e.size(), 32'd10);
    for (int i = 0; i < slip_e.size() && i < 10; i++) begin
      chk("wrap_edge", slip_e[i], 2048 * (i + 1));
      chk("wrap_val", slip_v[i], (i + 1) % 10);
    end
    chk("wrap_never_locked", any_lock, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
